// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage execute unit: ALU control codes,
// multiply/divide operation codes, ALUOp selector values and FSM states.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_ctrl_e;

    // Encoded to match funct3 so decode is a straight cast.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Operand A is treated as two's complement for these ops.
    function automatic logic md_a_signed(input md_op_e op);
        logic s;
        case (op)
            MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    // Operand B is treated as two's complement for these ops.
    function automatic logic md_b_signed(input md_op_e op);
        logic s;
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        logic d;
        case (op)
            MD_DIV, MD_DIVU, MD_REM, MD_REMU: d = 1'b1;
            default:                          d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide engine. Works on operand magnitudes, one bit
// per cycle for XLEN cycles, and fixes up signs on the final step. The
// result is presented combinationally in the cycle 'done' is high so the
// owner can register it on the same edge that retires the last step.
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            CW        = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [CW-1:0] STEP_ONE  = CW'(1);

    logic              running_r;
    logic [CW-1:0]     count_r;
    md_op_e            op_r;
    logic              is_div_r;
    logic              neg_q_r;   // product / quotient must be negated
    logic              neg_r_r;   // remainder must be negated (dividend sign)
    logic [XLEN-1:0]   opnd_r;    // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_r;     // mul: {partial, multiplier}; div: {rem, quotient}

    logic              sa_s;
    logic              sb_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     shifted_s;
    logic [XLEN:0]     diff_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Operand signs and magnitudes captured at start.
    always_comb begin
        sa_s    = md_a_signed(op) & op_a[XLEN-1];
        sb_s    = md_b_signed(op) & op_b[XLEN-1];
        mag_a_s = sa_s ? -op_a : op_a;
        mag_b_s = sb_s ? -op_b : op_b;
    end

    // One shift-add (mul) or restoring-subtract (div) step.
    always_comb begin
        sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]}
                  + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        shifted_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!diff_s[XLEN]) begin
                acc_next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and selection of the half / quotient / remainder.
    always_comb begin
        prod_fix_s = neg_q_r ? -acc_next_s : acc_next_s;
        quo_s      = acc_next_s[XLEN-1:0];
        rem_s      = acc_next_s[2*XLEN-1:XLEN];
        case (op_r)
            MD_MUL:                       result = prod_fix_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = neg_q_r ? -quo_s : quo_s;
            MD_REM, MD_REMU:              result = neg_r_r ? -rem_s : rem_s;
            default:                      result = '0;
        endcase
    end

    assign done = running_r && (count_r == LAST_STEP);

    // Engine state: load on start, then step once per cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_r <= 1'b0;
            count_r   <= '0;
            op_r      <= MD_MUL;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            opnd_r    <= '0;
            acc_r     <= '0;
        end else if (start) begin
            running_r <= 1'b1;
            count_r   <= '0;
            op_r      <= op;
            is_div_r  <= md_is_div(op);
            neg_q_r   <= sa_s ^ sb_s;
            neg_r_r   <= sa_s;
            if (md_is_div(op)) begin
                acc_r  <= {{XLEN{1'b0}}, mag_a_s};
                opnd_r <= mag_b_s;
            end else begin
                acc_r  <= {{XLEN{1'b0}}, mag_b_s};
                opnd_r <= mag_a_s;
            end
        end else if (running_r) begin
            acc_r   <= acc_next_s;
            count_r <= count_r + STEP_ONE;
            if (done) begin
                running_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_md_exec.sv
// EX-stage execute unit: decodes ALUOp/funct3/funct7, runs single-cycle
// base ALU ops directly and RV32M ops on the iterative engine, with a
// valid/ready handshake on both sides so the pipeline can stall.
module alu_md_exec
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            op_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int              SW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            illegal_r;
    logic            busy_r;

    alu_ctrl_e       ctrl_s;
    logic            is_md_s;
    logic            illegal_s;
    md_op_e          md_op_s;
    logic [SW-1:0]   shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            special_s;
    logic [XLEN-1:0] special_res_s;
    logic [XLEN-1:0] imm_res_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            start_md_s;
    logic            md_done_s;
    logic [XLEN-1:0] md_res_s;

    // Decode ALUOp and funct fields into a control code, M-op flag and legality.
    always_comb begin
        ctrl_s    = ALU_ADD;
        is_md_s   = 1'b0;
        illegal_s = 1'b0;
        md_op_s   = md_op_e'(funct3);
        case (alu_op)
            ALUOP_ADD: ctrl_s = ALU_ADD;
            ALUOP_SUB: ctrl_s = ALU_SUB;
            ALUOP_FUNCT: begin
                if (!op_imm && (funct7 != F7_BASE) && (funct7 != F7_ALT)
                    && (funct7 != F7_MULDIV)) begin
                    illegal_s = 1'b1;
                end else if (!op_imm && ENABLE_M && (funct7 == F7_MULDIV)) begin
                    is_md_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
                case (funct3)
                    3'b000:  ctrl_s = (!op_imm && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl_s = ALU_SLL;
                    3'b010:  ctrl_s = ALU_SLT;
                    3'b011:  ctrl_s = ALU_SLTU;
                    3'b100:  ctrl_s = ALU_XOR;
                    3'b101:  ctrl_s = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl_s = ALU_OR;
                    3'b111:  ctrl_s = ALU_AND;
                    default: ctrl_s = ALU_ADD;
                endcase
            end
            ALUOP_ILLEGAL: illegal_s = 1'b1;
            default:       illegal_s = 1'b1;
        endcase
    end

    // Single-cycle base ALU; illegal encodings produce zero.
    always_comb begin
        shamt_s = op_b[SW-1:0];
        case (ctrl_s)
            ALU_AND:  alu_res_s = op_a & op_b;
            ALU_OR:   alu_res_s = op_a | op_b;
            ALU_ADD:  alu_res_s = op_a + op_b;
            ALU_SUB:  alu_res_s = op_a - op_b;
            ALU_SLL:  alu_res_s = op_a << shamt_s;
            ALU_SRL:  alu_res_s = op_a >> shamt_s;
            ALU_SRA:  alu_res_s = $unsigned($signed(op_a) >>> shamt_s);
            ALU_XOR:  alu_res_s = op_a ^ op_b;
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_res_s = '0;
        endcase
        if (illegal_s) begin
            alu_res_s = '0;
        end else begin
            alu_res_s = alu_res_s;
        end
    end

    // Divide-by-zero and signed overflow resolve immediately without iterating.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = '0;
        if (is_md_s && md_is_div(md_op_s)) begin
            if (op_b == '0) begin
                special_s     = 1'b1;
                special_res_s = funct3[1] ? op_a : '1;
            end else if (!funct3[0] && (op_a == MIN_VAL) && (op_b == '1)) begin
                special_s     = 1'b1;
                special_res_s = funct3[1] ? '0 : MIN_VAL;
            end else begin
                special_s     = 1'b0;
            end
        end else begin
            special_s = 1'b0;
        end
        imm_res_s = special_s ? special_res_s : alu_res_s;
    end

    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign start_md_s = accept_s && is_md_s && !special_s;

    alu_md_iter #(
        .XLEN (XLEN)
    ) u_md_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_md_s),
        .op     (md_op_s),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (md_done_s),
        .result (md_res_s)
    );

    // Handshake FSM with registered result, flags and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b1;
            illegal_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (is_md_s && !special_s) begin
                            state_r     <= ST_CALC;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b1;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= imm_res_s;
                            zero_r      <= (imm_res_s == '0);
                            illegal_r   <= illegal_s;
                        end
                    end else if ((state_r == ST_DONE) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CALC: begin
                    if (md_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= md_res_s;
                        zero_r      <= (md_res_s == '0);
                        illegal_r   <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_md_exec.sv
// Scoreboard bench for alu_md_exec: directed vectors push expected results
// and latencies; a monitor compares whenever the DUT presents out_valid.
module tb_alu_md_exec;

    localparam int XLEN   = 32;
    localparam int MD_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic            op_imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   passed   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    bit   seen     = 1'b0;

    alu_md_exec #(
        .XLEN     (XLEN),
        .ENABLE_M (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_imm    (op_imm),
        .funct3    (funct3),
        .funct7    (funct7),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Count cycles with busy asserted.
    always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: latency on first sight, result/flags every cycle held, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out_valid: got result %h with no pending request", result);
            end else begin
                if (!seen) begin
                    check({sb_q[0].name, "_latency"}, 32'(cyc - sb_q[0].acc_cyc), 32'(sb_q[0].lat));
                    seen = 1'b1;
                end
                check({sb_q[0].name, "_result"}, result, sb_q[0].res);
                check({sb_q[0].name, "_zero"}, {31'd0, zero}, {31'd0, (sb_q[0].res == 32'd0)});
                check({sb_q[0].name, "_illegal"}, {31'd0, illegal}, {31'd0, sb_q[0].ill});
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] aop, input logic imm,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill, input int lat);
        exp_t e;
        bit   acc = 1'b0;
        int   n   = 0;
        alu_op = aop; op_imm = imm; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                acc       = 1'b1;
                e.res     = exp_res;
                e.ill     = exp_ill;
                e.lat     = lat;
                e.acc_cyc = cyc;
                e.name    = name;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL %s_accept: in_ready stayed 0 for 100 cycles, expected 1", name);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; op_imm = 1'b0; funct3 = 3'd0; funct7 = 7'd0;
        op_a = 32'd0; op_b = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Base ops, back-to-back
        issue("sub_r",   2'b10, 1'b0, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
        issue("addi_f7", 2'b10, 1'b1, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        issue("srai",    2'b10, 1'b1, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1);
        issue("srli",    2'b10, 1'b1, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1);
        issue("sltiu",   2'b10, 1'b1, 3'b011, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1);
        issue("add_ld",  2'b00, 1'b0, 3'b111, 7'b1111111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
        issue("sub_br",  2'b01, 1'b0, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd0, 1'b0, 1);
        issue("sll",     2'b10, 1'b0, 3'b001, 7'b0000000, 32'd1, 32'd35, 32'd8, 1'b0, 1);
        issue("slt",     2'b10, 1'b0, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
        issue("xor",     2'b10, 1'b0, 3'b100, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1);
        issue("or",      2'b10, 1'b0, 3'b110, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1);
        issue("and",     2'b10, 1'b0, 3'b111, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1);
        issue("sra_r",   2'b10, 1'b0, 3'b101, 7'b0100000, 32'h80000000, 32'd36, 32'hF8000000, 1'b0, 1);
        wait_drain();

        // Multiply, with busy duration
        b0 = busy_cnt;
        issue("mulh", 2'b10, 1'b0, 3'b001, 7'b0000001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, MD_LAT);
        wait_drain();
        check("mulh_busy_cycles", 32'(busy_cnt - b0), 32'd32);
        issue("mul",      2'b10, 1'b0, 3'b000, 7'b0000001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 1'b0, MD_LAT);
        issue("mulhsu",   2'b10, 1'b0, 3'b010, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, MD_LAT);
        issue("mulhu",    2'b10, 1'b0, 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, MD_LAT);
        issue("mulh_min", 2'b10, 1'b0, 3'b001, 7'b0000001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, MD_LAT);

        // Divide, including special cases
        issue("div_by0",  2'b10, 1'b0, 3'b100, 7'b0000001, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
        issue("rem_by0",  2'b10, 1'b0, 3'b110, 7'b0000001, 32'd7, 32'd0, 32'd7, 1'b0, 1);
        issue("divu_by0", 2'b10, 1'b0, 3'b101, 7'b0000001, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
        issue("div_ovf",  2'b10, 1'b0, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        issue("rem_ovf",  2'b10, 1'b0, 3'b110, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1);
        issue("div_neg",  2'b10, 1'b0, 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, MD_LAT);
        issue("rem_neg",  2'b10, 1'b0, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, MD_LAT);
        issue("divu",     2'b10, 1'b0, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, 1'b0, MD_LAT);
        issue("remu",     2'b10, 1'b0, 3'b111, 7'b0000001, 32'd100, 32'd7, 32'd2, 1'b0, MD_LAT);
        issue("divu_big", 2'b10, 1'b0, 3'b101, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, MD_LAT);
        wait_drain();

        // Consumer stall: result held, in_ready low; then release with a new request
        out_ready = 1'b0;
        issue("stall_xor", 2'b10, 1'b0, 3'b100, 7'b0000000, 32'h12345678, 32'h0000FFFF, 32'h1234A987, 1'b0, 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue("b2b_add", 2'b00, 1'b0, 3'b000, 7'b0000000, 32'd40, 32'd2, 32'd42, 1'b0, 1);
        wait_drain();

        // Reset during CALC aborts the operation
        issue("abort_mul", 2'b10, 1'b0, 3'b000, 7'b0000001, 32'd3, 32'd5, 32'd15, 1'b0, MD_LAT);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        check("abort_no_result", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Illegal encodings
        issue("aluop11", 2'b11, 1'b0, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 1'b1, 1);
        issue("f7_bad",  2'b10, 1'b0, 3'b000, 7'b0000010, 32'd5, 32'd7, 32'd0, 1'b1, 1);
        wait_drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
